// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// Holds the FSM state encoding and the counter sizing rule.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE,
    WAIT_LOW
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Control FSM and iteration counter for the multiplier.
// Emits load/shift/last strobes plus done and busy.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int CW    = cnt_bits(width)
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic load_o,
  output logic shift_o,
  output logic last_o,
  output logic done_o,
  output logic busy_o
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last;

  assign last = (state_q == CALC)
             && (cnt_q == CW'(width - 1));

  // state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and next count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CALC;
          cnt_d   = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = DONE;
      end
      DONE: begin
        state_d = start_i ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        if (!start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // strobes decoded from state
  always_comb begin
    load_o  = (state_q == IDLE) && start_i;
    shift_o = (state_q == CALC);
    last_o  = last;
    done_o  = (state_q == DONE);
    busy_o  = (state_q == CALC);
  end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier.
// One add/shift per clock; 2*width-bit product with done pulse.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [width-1:0]   OpA,
  input  logic [width-1:0]   OpB,
  output logic [2*width-1:0] product,
  output logic               done,
  output logic               busy
);

  logic               load, shift, last;
  logic [width-1:0]   m_q;
  logic [width:0]     a_q, a_d;
  logic [width-1:0]   q_q, q_d;
  logic [2*width-1:0] prod_q;
  logic [width:0]     sum;
  logic [2*width:0]   shifted;

  mul_ctrl #(.width(width)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .load_o  (load),
    .shift_o (shift),
    .last_o  (last),
    .done_o  (done),
    .busy_o  (busy)
  );

  // add when the multiplier LSB is set, then shift the pair right
  always_comb begin
    sum     = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
    shifted = {sum, q_q} >> 1;
    a_d     = shifted[2*width:width];
    q_d     = shifted[width-1:0];
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q    <= '0;
      a_q    <= '0;
      q_q    <= '0;
      prod_q <= '0;
    end else if (load) begin
      m_q <= OpA;
      a_q <= '0;
      q_q <= OpB;
    end else if (shift) begin
      a_q <= a_d;
      q_q <= q_d;
      if (last) prod_q <= shifted[2*width-1:0];
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul (width 8 and width 2).
// Expected products come from plain integer multiplication.
module tb_shift_add_mul;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] product;
  logic           done, busy;

  logic           start2;
  logic [1:0]     opa2, opb2;
  logic [3:0]     product2;
  logic           done2, busy2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int n_done2     = 0;

  typedef struct {
    logic [15:0] p;
    int          due;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  shift_add_mul #(.width(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .OpA     (opa),
    .OpB     (opb),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  shift_add_mul #(.width(2)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .start   (start2),
    .OpA     (opa2),
    .OpB     (opb2),
    .product (product2),
    .done    (done2),
    .busy    (busy2)
  );

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", n, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", 64'(product), 64'(e.p));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clk) if (done2) n_done2++;

  logic [15:0] last_p;

  task automatic issue(input logic [7:0] a,
                       input logic [7:0] b,
                       input int hold);
    exp_t e;
    @(negedge clk);
    opa   = a;
    opb   = b;
    start = 1'b1;
    @(negedge clk);
    e.p   = 16'(a) * 16'(b);
    e.due = cyc + W;
    last_p = e.p;
    q.push_back(e);
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 1; i < hold; i++) @(negedge clk);
    start = 1'b0;
    opa   = 8'($urandom);
    opb   = 8'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      chk("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opa    = '0;
    opb    = '0;
    start2 = 1'b0;
    opa2   = '0;
    opb2   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_product", 64'(product), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // nominal with start held three cycles
    issue(8'hE9, 8'hC3, 3);
    drain();
    repeat (3) @(negedge clk);
    chk("product_held", 64'(product), 64'hB17B);
    chk("busy_after_done", 64'(busy), 64'd0);

    // corner operands
    issue(8'hFF, 8'hFF, 1);
    drain();
    chk("ff_x_ff", 64'(product), 64'hFE01);
    issue(8'h00, 8'hA5, 1);
    drain();
    chk("zero_x_a5", 64'(product), 64'h0000);
    issue(8'h01, 8'h80, 1);
    drain();
    chk("one_x_80", 64'(product), 64'h0080);

    // operand change and start pulse during CALC
    issue(8'h12, 8'h34, 1);
    repeat (2) @(negedge clk);
    opa   = 8'hAA;
    opb   = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("mid_start_ignored", 64'(product), 64'h03A8);

    // reset during CALC aborts without done
    @(negedge clk);
    opa   = 8'h77;
    opb   = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_product", 64'(product), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (12) @(negedge clk);
    issue(8'h0F, 8'h0F, 1);
    drain();
    chk("after_abort", 64'(product), 64'h00E1);

    // randomized stream
    for (int k = 0; k < 40; k++) begin
      issue(8'($urandom), 8'($urandom),
            int'($urandom_range(1, 3)));
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // width-2 instance with start held high
    @(negedge clk);
    n_done2 = 0;
    opa2    = 2'd3;
    opb2    = 2'd3;
    start2  = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_done_count", 64'(n_done2), 64'd1);
    chk("held_product", 64'(product2), 64'd9);
    start2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_no_retrigger", 64'(n_done2), 64'd1);
    opa2   = 2'd2;
    opb2   = 2'd3;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    chk("rearm_done_count", 64'(n_done2), 64'd2);
    chk("rearm_product", 64'(product2), 64'd6);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
